window_gen_3x3: RTL
===================

WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 Parameter IMG_W, default 640, pixels per line; legal range 3..4096.
REQ-002 Parameter IMG_H, default 480, lines per frame; legal range 3..4096.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_pix carries a raster-order pixel this cycle.
REQ-006 in_pix  input  8  grayscale pixel, left-to-right, top-to-bottom.
REQ-007 win_valid  output  1  the nine window outputs hold a complete in-image 3x3 window.
REQ-008 IM_i_1_j_1, IM_i_1_j, IM_i_1_j__1  output  8 each  row i-1 (oldest) of the window, columns j-1, j, j+1.
REQ-009 IM_i_j_1, IM_i_j, IM_i_j__1  output  8 each  row i (centre row), columns j-1, j, j+1.
REQ-010 IM_i__1_j_1, IM_i__1_j, IM_i__1_j__1  output  8 each  row i+1 (newest) of the window, columns j-1, j, j+1.
REQ-011 ctr_row, ctr_col  output  $clog2(IMG_H), $clog2(IMG_W)  image coordinates (i, j) of the window centre; valid with win_valid.

Function
REQ-012 A pixel is accepted on any rising edge with in_valid=1. No backpressure: every offered pixel is consumed.
REQ-013 Input coordinates: column counter c runs 0..IMG_W-1 and row counter r runs 0..IMG_H-1. Both advance only on accept. c wraps to 0 and increments r. Accepting (IMG_H-1, IMG_W-1) wraps both to 0.
REQ-014 Two line buffers delay the stream by IMG_W and 2*IMG_W accepts. Together with the current pixel they feed a 3x3 register window that shifts one column per accept.
REQ-015 On the edge that accepts the pixel at (r,c), the window registers load the pixels at rows r-2..r and columns c-2..c. The centre coordinates are (r-1, c-1).
REQ-016 win_valid is registered. It is 1 in the cycle after an accept with r>=2 and c>=2, otherwise 0. Latency from accept to window is therefore 1 cycle.
REQ-017 A window that straddles a line or frame boundary (c<2 or r<2) never asserts win_valid. Each frame yields exactly (IMG_W-2)*(IMG_H-2) valid windows.
REQ-018 When in_valid=0, win_valid deasserts next cycle and the window outputs, ctr_row/ctr_col, counters and line buffers hold.
REQ-019 Window pixels are unsigned 8-bit values passed through with no arithmetic or saturation.

Reset
REQ-020 While rst_n=0: win_valid=0, all nine window outputs=0, ctr_row=ctr_col=0, r=c=0.
REQ-021 Line-buffer contents are not reset. Stale data can never appear under win_valid=1 (guaranteed by REQ-017).
REQ-022 Reset asserted mid-frame aborts the frame. The first pixel accepted after release is treated as (0,0).

Configuration
REQ-023 Macro WINGEN_FRAME_DONE_EN, when defined, adds output frame_done (1 bit, reset 0).
REQ-024 frame_done pulses for exactly one cycle, in the cycle after the accept of pixel (IMG_H-1, IMG_W-1), coincident with the last win_valid of the frame.
REQ-025 When WINGEN_FRAME_DONE_EN is undefined, the port and its logic do not exist. All other behaviour is identical.

Structure
REQ-026 Package wingen_pkg holds PIX_W=8, the default IMG_W/IMG_H constants, and a coordinate-width function.
REQ-027 Sub-module line_buf: parameterised IMG_W-deep, PIX_W-wide delay line with a shift enable. It is instantiated twice in cascade.

Verification (IMG_W=4, IMG_H=4, pixel value = 4r+c)
REQ-028 Reset, then stream 16 pixels back-to-back:
- The first win_valid comes in the cycle after pixel 10 is accepted.
- Row i-1 outputs are 0,1,2; row i outputs are 4,5,6; row i+1 outputs are 8,9,10.
- ctr_row=1, ctr_col=1.
REQ-029 Same stream: win_valid is high for exactly 4 cycles, with centres (1,1),(1,2),(2,1),(2,2). Windows are never valid after pixels 0-9, 12 or 13.
REQ-030 Insert 3 idle cycles (in_valid=0) after pixel 11:
- Window outputs hold at centre (1,2) values and win_valid=0 during the gap.
- Pixel 14 then yields centre (2,1) with IM_i_j=9.
REQ-031 Stream two frames back-to-back:
- Frame 2 pixels 0-9 produce no win_valid; no window mixes frames.
- Frame 2 pixel 10 reproduces the REQ-028 window.
- With WINGEN_FRAME_DONE_EN defined, frame_done pulses once per frame, after pixel 15.
REQ-032 Assert rst_n=0 after pixel 7, then release and stream 16 pixels:
- All outputs read 0 during reset.
- After release the behaviour equals REQ-028 exactly.

Source files
------------

// File: rtl/wingen_pkg.sv
// Shared constants and helpers for the 3x3 window generator.
package wingen_pkg;

    localparam int PIX_W     = 8;
    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    // Width of a coordinate counter that spans 0..n-1; never narrower than 1 bit.
    function automatic int coord_w(input int n);
        int w;
        if (n > 2) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/line_buf.sv
// IMG_W-deep delay line: dout is the sample pushed IMG_W enabled cycles earlier.
module line_buf
    import wingen_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int WIDTH = PIX_W
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem_q [IMG_W];
    logic [WIDTH-1:0] mem_d [IMG_W];

    // Next-state of the delay line: shift by one on enable, otherwise hold.
    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d[0] = din;
            for (int k = 1; k < IMG_W; k++) begin
                mem_d[k] = mem_q[k-1];
            end
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage is left unreset; stale entries are never exposed under a valid window.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout = mem_q[IMG_W-1];

endmodule

// File: rtl/window_gen_3x3.sv
// Raster-stream 3x3 window generator with centre coordinates.
// Optional frame_done output enabled by defining WINGEN_FRAME_DONE_EN.
module window_gen_3x3
    import wingen_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [PIX_W-1:0]           in_pix,
    output logic                       win_valid,
    output logic [PIX_W-1:0]           IM_i_1_j_1,
    output logic [PIX_W-1:0]           IM_i_1_j,
    output logic [PIX_W-1:0]           IM_i_1_j__1,
    output logic [PIX_W-1:0]           IM_i_j_1,
    output logic [PIX_W-1:0]           IM_i_j,
    output logic [PIX_W-1:0]           IM_i_j__1,
    output logic [PIX_W-1:0]           IM_i__1_j_1,
    output logic [PIX_W-1:0]           IM_i__1_j,
    output logic [PIX_W-1:0]           IM_i__1_j__1,
    output logic [coord_w(IMG_H)-1:0]  ctr_row,
    output logic [coord_w(IMG_W)-1:0]  ctr_col
`ifdef WINGEN_FRAME_DONE_EN
    ,
    output logic                       frame_done
`endif
);

    localparam int RW = coord_w(IMG_H);
    localparam int CW = coord_w(IMG_W);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);

    logic [PIX_W-1:0] lb1_out_s;
    logic [PIX_W-1:0] lb2_out_s;

    // win[row][col]: row 0 = i-1 (oldest), col 0 = j-1
    logic [2:0][2:0][PIX_W-1:0] win_q, win_d;
    logic [RW-1:0]              r_q, r_d;
    logic [CW-1:0]              c_q, c_d;
    logic [RW-1:0]              ctr_row_q, ctr_row_d;
    logic [CW-1:0]              ctr_col_q, ctr_col_d;
    logic                       win_valid_q, win_valid_d;
    logic                       frame_done_q, frame_done_d;
    logic [2:0][PIX_W-1:0]      col_in_s;

    line_buf #(.IMG_W(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk  (clk),
        .en   (in_valid),
        .din  (in_pix),
        .dout (lb1_out_s)
    );

    line_buf #(.IMG_W(IMG_W), .WIDTH(PIX_W)) u_lb2 (
        .clk  (clk),
        .en   (in_valid),
        .din  (lb1_out_s),
        .dout (lb2_out_s)
    );

    assign col_in_s[0] = lb2_out_s;
    assign col_in_s[1] = lb1_out_s;
    assign col_in_s[2] = in_pix;

    // Next-state: raster counters, window shift, centre coordinates and validity.
    always_comb begin
        win_d        = win_q;
        r_d          = r_q;
        c_d          = c_q;
        ctr_row_d    = ctr_row_q;
        ctr_col_d    = ctr_col_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (in_valid) begin
            for (int rr = 0; rr < 3; rr++) begin
                win_d[rr][0] = win_q[rr][1];
                win_d[rr][1] = win_q[rr][2];
                win_d[rr][2] = col_in_s[rr];
            end
            // Centre lags the accepted pixel by one row and one column.
            ctr_row_d    = r_q - RW'(1);
            ctr_col_d    = c_q - CW'(1);
            win_valid_d  = (r_q >= RW'(2)) && (c_q >= CW'(2));
            frame_done_d = (r_q == R_LAST) && (c_q == C_LAST);
            if (c_q == C_LAST) begin
                c_d = '0;
                if (r_q == R_LAST) begin
                    r_d = '0;
                end else begin
                    r_d = r_q + RW'(1);
                end
            end else begin
                c_d = c_q + CW'(1);
                r_d = r_q;
            end
        end else begin
            win_valid_d  = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    // State registers, cleared asynchronously so a new frame starts at (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q        <= '0;
            r_q          <= '0;
            c_q          <= '0;
            ctr_row_q    <= '0;
            ctr_col_q    <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            win_q        <= win_d;
            r_q          <= r_d;
            c_q          <= c_d;
            ctr_row_q    <= ctr_row_d;
            ctr_col_q    <= ctr_col_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_valid    = win_valid_q;
    assign ctr_row      = ctr_row_q;
    assign ctr_col      = ctr_col_q;
    assign IM_i_1_j_1   = win_q[0][0];
    assign IM_i_1_j     = win_q[0][1];
    assign IM_i_1_j__1  = win_q[0][2];
    assign IM_i_j_1     = win_q[1][0];
    assign IM_i_j       = win_q[1][1];
    assign IM_i_j__1    = win_q[1][2];
    assign IM_i__1_j_1  = win_q[2][0];
    assign IM_i__1_j    = win_q[2][1];
    assign IM_i__1_j__1 = win_q[2][2];

`ifdef WINGEN_FRAME_DONE_EN
    assign frame_done = frame_done_q;
`else
    logic unused_fd_s;
    assign unused_fd_s = frame_done_q;
`endif

endmodule
